// File: rtl/dct_pkg.sv
// Shared constants, mode encoding and the elaboration-time DCT coefficient generator.
// Coefficients come from an integer cosine table so no real arithmetic is needed.
package dct_pkg;
   localparam int N = 8;

   typedef enum logic {DCT_FWD = 1'b0, DCT_INV = 1'b1} dct_mode_e;

   // cos(m*pi/16) scaled by 2^30, m = 0..8
   function automatic longint cos16(input int m);
      case (m)
         0:       return 1073741824;
         1:       return 1053110176;
         2:       return 992008094;
         3:       return 892783698;
         4:       return 759250125;
         5:       return 596538995;
         6:       return 410903207;
         7:       return 209476638;
         default: return 0;
      endcase
   endfunction

   // round(0.5*c_k*cos((2n+1)k*pi/16)*2^(width-1)), half away from zero; width <= 31
   function automatic int coe(input int k, input int n, input int width);
      int     m;
      longint v;
      longint mag;
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (k == 0)     v = 759250125;
      else if (m > 8) v = -cos16(16 - m);
      else            v = cos16(m);
      mag = (v < 0) ? -v : v;
      mag = (mag + (64'sd1 <<< (31 - width))) >>> (32 - width);
      return (v < 0) ? -int'(mag) : int'(mag);
   endfunction
endpackage

// File: rtl/dct1d_stream_lane.sv
// One lane: eight MAC accumulators feeding a rounded, saturated output bank.
module dct1d_stream_lane import dct_pkg::*; #(
   parameter int IN_WIDTH  = 10,
   parameter int COE_WIDTH = 10,
   parameter int OUT_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         acc_en,
   input  logic                         first,
   input  logic                         xfer,
   input  logic signed [IN_WIDTH-1:0]   x,
   input  logic [N-1:0][COE_WIDTH-1:0]  coefs,
   input  logic [2:0]                   sel,
   output logic [OUT_WIDTH-1:0]         y
);
   localparam int AW = IN_WIDTH + COE_WIDTH + 3;
   localparam logic signed [AW:0] RND  = (AW+1)'(2 ** (COE_WIDTH - 2));
   localparam logic signed [AW:0] MAXV = (AW+1)'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [AW:0] MINV = (AW+1)'(-(2 ** (OUT_WIDTH - 1)));

   logic signed [AW-1:0]        acc  [N];
   logic signed [AW-1:0]        prod [N];
   logic signed [AW-1:0]        sum  [N];
   logic signed [AW:0]          rnd  [N];
   logic signed [AW:0]          sh   [N];
   logic signed [OUT_WIDTH-1:0] sat  [N];
   logic signed [OUT_WIDTH-1:0] bank [N];

   always_comb begin
      for (int j = 0; j < N; j++) begin
         prod[j] = AW'(x) * AW'($signed(coefs[j]));
         sum[j]  = first ? prod[j] : acc[j] + prod[j];
         rnd[j]  = (AW+1)'(sum[j]) + RND;
         sh[j]   = rnd[j] >>> (COE_WIDTH - 1);
         if (sh[j] > MAXV)      sat[j] = OUT_WIDTH'(MAXV);
         else if (sh[j] < MINV) sat[j] = OUT_WIDTH'(MINV);
         else                   sat[j] = OUT_WIDTH'(sh[j]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N; j++) begin
            acc[j]  <= '0;
            bank[j] <= '0;
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            if (acc_en) acc[j]  <= sum[j];
            if (xfer)   bank[j] <= sat[j];
         end
      end
   end

   assign y = bank[sel];
endmodule

// File: rtl/dct_coe_table.sv
// Combinational coefficient row for sample index idx: C[j][idx] forward, C[idx][j] inverse.
module dct_coe_table import dct_pkg::*; #(
   parameter int COE_WIDTH = 10
) (
   input  logic [2:0]                   idx,
   input  dct_mode_e                    mode,
   output logic [N-1:0][COE_WIDTH-1:0]  coefs
);
   logic [N-1:0][N-1:0][COE_WIDTH-1:0] tbl;

   for (genvar k = 0; k < N; k++) begin : g_k
      for (genvar n = 0; n < N; n++) begin : g_n
         localparam int CV = coe(k, n, COE_WIDTH);
         assign tbl[k][n] = COE_WIDTH'(CV);
      end
   end

   always_comb begin
      for (int j = 0; j < N; j++)
         coefs[j] = (mode == DCT_FWD) ? tbl[j][idx] : tbl[idx][j];
   end
endmodule

// File: rtl/dct1d_stream.sv
// Streaming 8-point DCT-II/DCT-III over CHANNELS lanes with double-banked in/out.
// Lanes share one handshake, one sample counter and one coefficient row.
module dct1d_stream import dct_pkg::*; #(
   parameter int IN_WIDTH  = 10,
   parameter int COE_WIDTH = 10,
   parameter int OUT_WIDTH = 12,
   parameter int CHANNELS  = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*IN_WIDTH-1:0]   in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CHANNELS*OUT_WIDTH-1:0]  out_data,
   output logic [2:0]                     out_idx,
   output logic                           out_last
);
   logic [2:0]                  in_cnt, out_cnt;
   logic                        ob_full;
   dct_mode_e                   blk_mode, cur_mode;
   logic                        out_hs, acc_en, xfer, first;
   logic [N-1:0][COE_WIDTH-1:0] coefs;

   assign out_hs   = ob_full & out_ready;
   // The last drain frees the bank in the same cycle a new block lands in it.
   assign in_ready = (in_cnt != 3'd7) | !ob_full | (out_hs & (out_cnt == 3'd7));
   assign acc_en   = in_valid & in_ready & !clear;
   assign first    = (in_cnt == 3'd0);
   assign xfer     = acc_en & (in_cnt == 3'd7);
   assign cur_mode = first ? dct_mode_e'(mode) : blk_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt   <= '0;
         out_cnt  <= '0;
         ob_full  <= 1'b0;
         blk_mode <= DCT_FWD;
      end else begin
         if (clear)       in_cnt <= '0;
         else if (acc_en) in_cnt <= in_cnt + 3'd1;
         if (acc_en && first) blk_mode <= cur_mode;
         if (xfer) begin
            ob_full <= 1'b1;
            out_cnt <= '0;
         end else if (out_hs) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd7) ob_full <= 1'b0;
         end
      end
   end

   assign out_valid = ob_full;
   assign out_idx   = out_cnt;
   assign out_last  = ob_full & (out_cnt == 3'd7);

   dct_coe_table #(.COE_WIDTH(COE_WIDTH)) u_coe (
      .idx   (in_cnt),
      .mode  (cur_mode),
      .coefs (coefs)
   );

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      dct1d_stream_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .COE_WIDTH (COE_WIDTH),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .acc_en (acc_en),
         .first  (first),
         .xfer   (xfer),
         .x      (in_data[c*IN_WIDTH +: IN_WIDTH]),
         .coefs  (coefs),
         .sel    (out_cnt),
         .y      (out_data[c*OUT_WIDTH +: OUT_WIDTH])
      );
   end
endmodule

// File: tb/tb_dct1d_stream.sv
// Randomised bench for dct1d_stream against a real-arithmetic DCT model and a queue
// of pending results; a second instance with OUT_WIDTH=10 exercises saturation.
module tb_dct1d_stream;
   localparam int IW = 10, CW = 10, OW = 12, OW2 = 10, CH = 3;
   localparam real PI = 3.14159265358979;

   logic clk = 0, rst_n = 1, clear = 0, mode = 0, in_valid = 0, out_ready = 1;
   logic [CH*IW-1:0]  in_data = '0;
   logic              in_ready, out_valid, out_last;
   logic [CH*OW-1:0]  out_data;
   logic [2:0]        out_idx;
   logic              s_in_ready, s_out_valid, s_out_last;
   logic [CH*OW2-1:0] s_out_data;
   logic [2:0]        s_out_idx;

   dct1d_stream #(.IN_WIDTH(IW), .COE_WIDTH(CW), .OUT_WIDTH(OW), .CHANNELS(CH)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last));

   dct1d_stream #(.IN_WIDTH(IW), .COE_WIDTH(CW), .OUT_WIDTH(OW2), .CHANNELS(CH)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .in_valid(in_valid),
      .in_ready(s_in_ready), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last));

   always #5 clk = ~clk;

   int vectors = 0, errors = 0, cyc = 0, acc_cnt = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int cref(input int k, input int n);
      real r;
      r = 0.5 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) * $cos((2 * n + 1) * k * PI / 16.0) * (2.0 ** (CW - 1));
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic int dct_raw(input int xs[8], input bit inv, input int j);
      longint s = 0;
      for (int i = 0; i < 8; i++) s += longint'(xs[i]) * (inv ? cref(i, j) : cref(j, i));
      return int'($floor((real'(s) + 2.0 ** (CW - 2)) / (2.0 ** (CW - 1))));
   endfunction

   function automatic int satw(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   typedef struct packed { logic [2:0] idx; logic [CH-1:0][31:0] raw; } res_t;
   res_t exp_q[$];
   int   blk_x[8][CH];
   int   blk_n = 0;
   bit   blk_md = 0;
   int   cap_m[8][CH], cap_s[8][CH];

   // single compare process: outputs, handshake readiness and model update each cycle
   always @(negedge clk) begin
      res_t e;
      bit   exp_rdy;
      int   col[8];
      if (!rst_n) begin
         exp_q.delete();
         blk_n = 0;
      end else begin
         exp_rdy = (blk_n != 7) || (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("sat_in_ready", s_in_ready, exp_rdy);
         chk("out_valid", out_valid, exp_q.size() != 0);
         chk("sat_out_valid", s_out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("out_idx", out_idx, e.idx);
            chk("out_last", out_last, e.idx == 3'd7);
            chk("sat_out_idx", s_out_idx, e.idx);
            for (int c = 0; c < CH; c++) begin
               chk($sformatf("lane%0d_data", c), $signed(out_data[c*OW +: OW]), satw(int'(e.raw[c]), OW));
               chk($sformatf("sat_lane%0d_data", c), $signed(s_out_data[c*OW2 +: OW2]), satw(int'(e.raw[c]), OW2));
            end
            if (out_ready) begin
               for (int c = 0; c < CH; c++) begin
                  cap_m[e.idx][c] = $signed(out_data[c*OW +: OW]);
                  cap_s[e.idx][c] = $signed(s_out_data[c*OW2 +: OW2]);
               end
               void'(exp_q.pop_front());
            end
         end else begin
            chk("out_last_idle", out_last, 0);
         end
         if (clear) blk_n = 0;
         else if (in_valid && exp_rdy) begin
            if (blk_n == 0) blk_md = mode;
            for (int c = 0; c < CH; c++) blk_x[blk_n][c] = $signed(in_data[c*IW +: IW]);
            blk_n++;
            acc_cnt++;
            if (blk_n == 8) begin
               for (int j = 0; j < 8; j++) begin
                  e.idx = 3'(j);
                  for (int c = 0; c < CH; c++) begin
                     for (int i = 0; i < 8; i++) col[i] = blk_x[i][c];
                     e.raw[c] = dct_raw(col, blk_md, j);
                  end
                  exp_q.push_back(e);
               end
               blk_n = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int bx[8][CH];
   int xo[8][CH];
   bit done;

   task automatic send_one();
      bit ok = 0;
      in_valid = 1;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      if (!ok) chk("send_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
      end
      in_valid = 0;
   endtask

   task automatic send_block(input bit md, input bit tog);
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < CH; c++) in_data[c*IW +: IW] = IW'(bx[i][c]);
         mode = (tog && i > 0) ? ~md : md;
         send_one();
      end
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && blk_n == 0) ok = 1;
      end
      if (!ok) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand(input int lo, input int hi);
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < CH; c++) bx[i][c] = $urandom_range(hi - lo) + lo;
   endtask

   task automatic fill_impulse();
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < CH; c++) bx[i][c] = (i == 0) ? 256 : 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int col[8];
      int t0;
      // reset values
      #1 rst_n = 0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // hand-computed anchors for the model
      for (int i = 0; i < 8; i++) col[i] = (i == 0) ? 256 : 0;
      chk("model_imp_X0", dct_raw(col, 0, 0), 91);
      chk("model_imp_X1", dct_raw(col, 0, 1), 126);
      for (int i = 0; i < 8; i++) col[i] = 100;
      chk("model_dc_X0", dct_raw(col, 0, 0), 283);
      chk("model_dc_X5", dct_raw(col, 0, 5), 0);
      for (int i = 0; i < 8; i++) col[i] = 511;
      chk("model_sat_X0", satw(dct_raw(col, 0, 0), OW2), 511);

      // impulse, forward; first result visible right after the 8th accept
      fill_impulse();
      send_block(0, 0);
      chk("latency_valid", out_valid, 1);
      wait_drain();
      for (int c = 0; c < CH; c++) begin
         chk("imp_X0", cap_m[0][c], 91);
         chk("imp_X1", cap_m[1][c], 126);
      end

      // DC block
      for (int i = 0; i < 8; i++) for (int c = 0; c < CH; c++) bx[i][c] = 100;
      send_block(0, 0);
      wait_drain();
      chk("dc_X0", cap_m[0][1], 283);
      for (int k = 1; k < 8; k++) chk("dc_Xk", cap_m[k][2], 0);

      // saturation with distinct lane patterns
      for (int i = 0; i < 8; i++) begin
         bx[i][0] = 511;
         bx[i][1] = -512;
         bx[i][2] = i * 50 - 175;
      end
      send_block(0, 0);
      wait_drain();
      chk("sat_X0_pos", cap_s[0][0], 511);
      chk("sat_X0_neg", cap_s[0][1], -512);
      chk("sat_X1_pos", cap_s[1][0], 0);

      // sustained throughput: 32 samples in 32 cycles
      t0 = cyc;
      for (int b = 0; b < 4; b++) begin
         fill_rand(-512, 511);
         send_block(b[0], b[1]);
      end
      chk("throughput_cycles", cyc - t0, 32);
      wait_drain();

      // backpressure: 24 samples with out_ready low
      out_ready = 0;
      t0 = acc_cnt;
      fork
         for (int b = 0; b < 3; b++) begin
            fill_rand(-512, 511);
            send_block(0, 0);
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            chk("bp_accepted", acc_cnt - t0, 15);
            out_ready = 1;
         end
      join
      wait_drain();

      // random modes and random out_ready
      done = 0;
      fork
         begin
            for (int b = 0; b < 12; b++) begin
               fill_rand(-512, 511);
               send_block(1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            done = 1;
         end
         while (!done) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(1));
         end
      join
      out_ready = 1;
      wait_drain();

      // round trip: forward then inverse (mode toggled mid-block, must be ignored)
      fill_rand(-128, 127);
      xo = bx;
      send_block(0, 0);
      wait_drain();
      for (int c = 0; c < CH; c++) begin
         for (int i = 0; i < 8; i++) col[i] = xo[i][c];
         for (int k = 0; k < 8; k++) bx[k][c] = satw(dct_raw(col, 0, k), OW);
      end
      send_block(1, 1);
      wait_drain();
      for (int n = 0; n < 8; n++)
         for (int c = 0; c < CH; c++) begin
            vectors++;
            if (cap_m[n][c] - xo[n][c] > 2 || xo[n][c] - cap_m[n][c] > 2) begin
               errors++;
               $display("FAIL roundtrip n%0d lane%0d: got %0d expected %0d +/-2", n, c, cap_m[n][c], xo[n][c]);
            end
         end

      // clear after 3 samples (clear beats a coincident sample), then impulse
      fill_rand(-512, 511);
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < CH; c++) in_data[c*IW +: IW] = IW'(bx[i][c]);
         send_one();
      end
      clear = 1;
      in_valid = 1;
      @(posedge clk);
      #1 clear = 0;
      in_valid = 0;
      fill_impulse();
      send_block(0, 0);
      wait_drain();
      chk("clr_X0", cap_m[0][0], 91);
      chk("clr_X1", cap_m[1][2], 126);

      // reset mid-block and mid-drain
      out_ready = 0;
      fill_rand(-512, 511);
      send_block(0, 0);
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < CH; c++) in_data[c*IW +: IW] = IW'(bx[i][c]);
         send_one();
      end
      out_ready = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_idx", out_idx, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_sat_data", s_out_data, 0);
      @(posedge clk);
      #1 rst_n = 1;
      fill_impulse();
      send_block(0, 0);
      wait_drain();
      chk("post_rst_X0", cap_m[0][1], 91);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
